mem_port_arbiter: RTL

Shares one single-port instruction/data RAM between the fetch stage and the load/store (write-back) stage. Arbitrates between them with a starvation guard, formats sub-word load results, and turns byte/halfword stores into a read-modify-write sequence. Sits between the fetch/write-back logic and a single-port `ram` instance with one-cycle read latency.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the single-port RAM.
// The arbiter uses the slave view; the requester/RAM side uses the master view.
interface mem_port_arbiter_if #(
  parameter int cXLEN  = 32,
  parameter int cAddrW = 10
);
  logic              iFReq;
  logic [cAddrW-1:0] iFAddr;
  logic              oFGnt;
  logic              oFDv;
  logic [cXLEN-1:0]  oFData;

  logic              iLsReq;
  logic              iLsWrite;
  logic [1:0]        iLsSize;
  logic              iLsUnsigned;
  logic [1:0]        iLsByteOff;
  logic [cAddrW-1:0] iLsAddr;
  logic [cXLEN-1:0]  iLsData;
  logic              oLsGnt;
  logic              oLsDv;
  logic [cXLEN-1:0]  oLsData;

  logic              oRamEn;
  logic              oRamWEn;
  logic [cAddrW-1:0] oRamAddr;
  logic [cXLEN-1:0]  oRamWData;
  logic [cXLEN-1:0]  iRamRData;

  logic              oBusy;

  modport slave (
    input  iFReq, iFAddr, iLsReq, iLsWrite, iLsSize, iLsUnsigned, iLsByteOff,
           iLsAddr, iLsData, iRamRData,
    output oFGnt, oFDv, oFData, oLsGnt, oLsDv, oLsData,
           oRamEn, oRamWEn, oRamAddr, oRamWData, oBusy
  );

  modport master (
    output iFReq, iFAddr, iLsReq, iLsWrite, iLsSize, iLsUnsigned, iLsByteOff,
           iLsAddr, iLsData, iRamRData,
    input  oFGnt, oFDv, oFData, oLsGnt, oLsDv, oLsData,
           oRamEn, oRamWEn, oRamAddr, oRamWData, oBusy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and load/store with a starvation guard,
// sub-word load extension and read-modify-write for byte/halfword stores.
module mem_port_arbiter #(
  parameter int cXLEN       = 32,
  parameter int cAddrW      = 10,
  parameter int cMaxLsBurst = 4
) (
  input logic                iClk,
  input logic                iRst,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned cStrW = $clog2(cMaxLsBurst + 1);
  localparam logic [cStrW-1:0] cStrMax = cStrW'(cMaxLsBurst);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW} state_e;

  state_e            state_q, state_d;
  logic [cStrW-1:0]  ls_streak_q, ls_streak_d;
  logic              rd_fetch_q, rd_fetch_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;
  logic [cAddrW-1:0] addr_q, addr_d;
  logic [cXLEN-1:0]  wdata_q, wdata_d;
  logic              f_dv_q, f_dv_d;
  logic              ls_dv_q, ls_dv_d;
  logic [cXLEN-1:0]  f_data_q, f_data_d;
  logic [cXLEN-1:0]  ls_data_q, ls_data_d;

  logic              f_win, ls_win, ls_word_store;
  logic [4:0]        shamt;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [cXLEN-1:0]  ls_ext, lane_mask, merged;
  logic              ram_en, ram_wen;
  logic [cAddrW-1:0] ram_addr;
  logic [cXLEN-1:0]  ram_wdata;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      ls_streak_q <= '0;
      rd_fetch_q  <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f_dv_q      <= 1'b0;
      ls_dv_q     <= 1'b0;
      f_data_q    <= '0;
      ls_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ls_streak_q <= ls_streak_d;
      rd_fetch_q  <= rd_fetch_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f_dv_q      <= f_dv_d;
      ls_dv_q     <= ls_dv_d;
      f_data_q    <= f_data_d;
      ls_data_q   <= ls_data_d;
    end
  end

  // Load/store has priority unless it has already taken cMaxLsBurst grants past a waiting fetch.
  always_comb begin
    f_win  = (state_q == IDLE) && bus.iFReq &&
             (!bus.iLsReq || (ls_streak_q == cStrMax));
    ls_win = (state_q == IDLE) && bus.iLsReq && !f_win;
    ls_word_store = bus.iLsWrite && bus.iLsSize[1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (f_win) begin
          state_d = RD_WAIT;
        end else if (ls_win) begin
          if (!bus.iLsWrite)      state_d = RD_WAIT;
          else if (!ls_word_store) state_d = RMW;
        end
      end
      RD_WAIT: state_d = IDLE;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ls_streak_d = ls_streak_q;
    if (!bus.iFReq || f_win) begin
      ls_streak_d = '0;
    end else if (ls_win && (ls_streak_q != cStrMax)) begin
      ls_streak_d = ls_streak_q + cStrW'(1);
    end

    rd_fetch_d = rd_fetch_q;
    size_d     = size_q;
    off_d      = off_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (f_win) begin
      rd_fetch_d = 1'b1;
    end else if (ls_win) begin
      rd_fetch_d = 1'b0;
      size_d     = bus.iLsSize;
      off_d      = bus.iLsByteOff;
      uns_d      = bus.iLsUnsigned;
      addr_d     = bus.iLsAddr;
      wdata_d    = bus.iLsData;
    end

    // Halfword lanes ignore the low offset bit; byte lanes use the full offset.
    shamt     = (size_q == 2'b01) ? {off_q[1], 4'b0000} : {off_q, 3'b000};
    rd_byte   = bus.iRamRData[{off_q, 3'b000} +: 8];
    rd_half   = bus.iRamRData[{off_q[1], 4'b0000} +: 16];
    lane_mask = (size_q == 2'b01) ? (cXLEN'(16'hFFFF) << shamt) : (cXLEN'(8'hFF) << shamt);
    merged    = (bus.iRamRData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    unique case (size_q)
      2'b00:   ls_ext = {{(cXLEN-8){~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   ls_ext = {{(cXLEN-16){~uns_q & rd_half[15]}}, rd_half};
      default: ls_ext = bus.iRamRData;
    endcase

    f_dv_d    = (state_q == RD_WAIT) && rd_fetch_q;
    ls_dv_d   = (state_q == RD_WAIT) && !rd_fetch_q;
    f_data_d  = f_dv_d  ? bus.iRamRData : f_data_q;
    ls_data_d = ls_dv_d ? ls_ext        : ls_data_q;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (f_win) begin
          ram_en   = 1'b1;
          ram_addr = bus.iFAddr;
        end else if (ls_win) begin
          ram_en   = 1'b1;
          ram_addr = bus.iLsAddr;
          if (ls_word_store) begin
            ram_wen   = 1'b1;
            ram_wdata = bus.iLsData;
          end
        end
      end
      RMW: begin
        ram_en    = 1'b1;
        ram_wen   = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = merged;
      end
      default: ;
    endcase

    // Combinational strobes are forced low while reset is held so an in-flight RMW cannot write.
    bus.oFGnt     = !iRst && f_win;
    bus.oLsGnt    = !iRst && ls_win;
    bus.oRamEn    = !iRst && ram_en;
    bus.oRamWEn   = !iRst && ram_wen;
    bus.oRamAddr  = iRst ? '0 : ram_addr;
    bus.oRamWData = iRst ? '0 : ram_wdata;
    bus.oFDv      = f_dv_q;
    bus.oFData    = f_data_q;
    bus.oLsDv     = ls_dv_q;
    bus.oLsData   = ls_data_q;
    bus.oBusy     = (state_q != IDLE);
  end
endmodule
